// File: rtl/linear_ccd_timing_gen_if.sv
// rtl/linear_ccd_timing_gen_if.sv - signal bundle between acquisition control and the CCD timing generator
// master: acquisition control (drives mode/start/stop/trig_in/int_time)
// slave : timing generator (drives sensor waveforms, ADC strobe and frame status)
interface linear_ccd_timing_gen_if #(
  parameter int INT_W = 16
);
  logic [1:0]       mode;
  logic             start;
  logic             stop;
  logic             trig_in;
  logic [INT_W-1:0] int_time;
  logic             ccd_clk;
  logic             ccd_rog;
  logic             adc_strobe;
  logic [15:0]      pix_idx;
  logic             frame_start;
  logic             frame_done;
  logic             busy;
  logic             integ_active;
  logic             trig_miss;

  modport master (
    output mode, start, stop, trig_in, int_time,
    input  ccd_clk, ccd_rog, adc_strobe, pix_idx, frame_start, frame_done,
           busy, integ_active, trig_miss
  );

  modport slave (
    input  mode, start, stop, trig_in, int_time,
    output ccd_clk, ccd_rog, adc_strobe, pix_idx, frame_start, frame_done,
           busy, integ_active, trig_miss
  );
endinterface

// File: rtl/linear_ccd_timing_gen.sv
// rtl/linear_ccd_timing_gen.sv - ROG/CLK timing generator for ILX511B-class linear CCDs
// Ports:
//   sys_clk  - system clock, all logic on rising edge
//   sys_rst  - synchronous active-high reset
//   bus      - slave side of linear_ccd_timing_gen_if:
//              in : mode, start, stop, trig_in, int_time
//              out: ccd_clk, ccd_rog (active low), adc_strobe, pix_idx,
//                   frame_start, frame_done, busy, integ_active, trig_miss
module linear_ccd_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int N_PIX     = 2087,
  parameter int ROG_SETUP = 3,
  parameter int ROG_LOW   = 149,
  parameter int ROG_HOLD  = 2,
  parameter int TICK_DIV  = 100000,
  parameter int ADC_PHASE = 2,
  parameter int INT_W     = 16
) (
  input logic                    sys_clk,
  input logic                    sys_rst,
  linear_ccd_timing_gen_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, FLUSH_SETUP, FLUSH_ROG, INTEG, XFER_SETUP, XFER_ROG, HOLD, READOUT, WAIT_INT
  } state_t;

  localparam int MAX_A   = (ROG_LOW > ROG_SETUP) ? ROG_LOW : ROG_SETUP;
  localparam int CNT_MAX = (MAX_A > ROG_HOLD) ? MAX_A : ROG_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PH_W    = $clog2(2 * CLK_DIV);
  localparam int TK_W    = $clog2(TICK_DIV + 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [PH_W-1:0]  ph;
  logic [15:0]      pix;
  logic             last_pix;
  logic [1:0]       mode_lat;
  logic             stop_pending;
  logic             int_done;
  logic             integ_q;
  logic [TK_W-1:0]  tick_cnt;
  logic [INT_W-1:0] tick_num;
  logic [INT_W-1:0] int_lat;
  logic             rog_q;
  logic             miss_q;

  logic accept, setup_end, rog_end, hold_end, pix_end, ro_end;
  logic expire, int_ready, rog_rise, rog_fall, timed;

  always_comb begin
    accept    = (state == IDLE) && ((bus.mode == 2'd2) ? bus.trig_in : bus.start);
    setup_end = (cnt == CNT_W'(ROG_SETUP - 1));
    rog_end   = (cnt == CNT_W'(ROG_LOW - 1));
    hold_end  = (cnt == CNT_W'(ROG_HOLD - 1));
    pix_end   = (ph == PH_W'(2 * CLK_DIV - 1));
    ro_end    = pix_end && last_pix;
    // expiry is seen combinationally so INTEG/WAIT_INT leave on the very cycle the timer ends
    expire    = integ_q && (tick_cnt == TK_W'(TICK_DIV - 1)) && (tick_num == int_lat - INT_W'(1));
    int_ready = int_done || expire;
    rog_rise  = ((state == FLUSH_ROG) || (state == XFER_ROG)) && rog_end;
    rog_fall  = ((state == FLUSH_SETUP) || (state == XFER_SETUP)) && setup_end;
    timed     = (state == FLUSH_SETUP) || (state == FLUSH_ROG) || (state == XFER_SETUP) ||
                (state == XFER_ROG) || (state == HOLD);
  end

  // state register; ccd_rog is registered from the next state so it is low exactly in *_ROG
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      rog_q <= 1'b1;
    end else begin
      state <= next_state;
      rog_q <= !((next_state == FLUSH_ROG) || (next_state == XFER_ROG));
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (accept) next_state = FLUSH_SETUP;
      FLUSH_SETUP: if (setup_end) next_state = FLUSH_ROG;
      FLUSH_ROG:   if (rog_end) next_state = INTEG;
      INTEG:       if (int_ready) next_state = XFER_SETUP;
      XFER_SETUP:  if (setup_end) next_state = XFER_ROG;
      XFER_ROG:    if (rog_end) next_state = HOLD;
      HOLD:        if (hold_end) next_state = READOUT;
      READOUT: begin
        if (ro_end) begin
          if (mode_lat != 2'd1 || stop_pending) next_state = IDLE;
          else if (int_ready)                   next_state = XFER_SETUP;
          else                                  next_state = WAIT_INT;
        end
      end
      WAIT_INT:    if (int_ready) next_state = XFER_SETUP;
      default:     next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.ccd_clk     = 1'b1;
    bus.adc_strobe  = 1'b0;
    bus.frame_start = 1'b0;
    bus.frame_done  = 1'b0;
    if (state == READOUT) begin
      bus.ccd_clk     = (ph >= PH_W'(CLK_DIV));
      bus.adc_strobe  = (ph == PH_W'(ADC_PHASE));
      bus.frame_start = (ph == '0) && (pix == 16'd0);
      bus.frame_done  = ro_end;
    end
    bus.ccd_rog      = rog_q;
    bus.pix_idx      = pix;
    bus.busy         = (state != IDLE);
    bus.integ_active = integ_q;
    bus.trig_miss    = miss_q;
  end

  // phase counters; pixel counters are held at zero whenever the next state is not READOUT,
  // which also returns pix_idx to 0 right after the last pixel
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt      <= '0;
      ph       <= '0;
      pix      <= '0;
      last_pix <= 1'b0;
    end else begin
      cnt <= (next_state != state || !timed) ? '0 : cnt + CNT_W'(1);
      if (next_state != READOUT) begin
        ph       <= '0;
        pix      <= '0;
        last_pix <= 1'b0;
      end else if (state == READOUT) begin
        ph <= pix_end ? '0 : ph + PH_W'(1);
        if (ph == PH_W'(CLK_DIV - 1)) begin
          if (pix == 16'(N_PIX - 1)) last_pix <= 1'b1;
          else                       pix      <= pix + 16'd1;
        end
      end
    end
  end

  // mode latch, stop request, integration timer and miss pulse
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mode_lat     <= 2'd0;
      stop_pending <= 1'b0;
      int_done     <= 1'b0;
      integ_q      <= 1'b0;
      tick_cnt     <= '0;
      tick_num     <= '0;
      int_lat      <= '0;
      miss_q       <= 1'b0;
    end else begin
      miss_q <= (state != IDLE) && (bus.start || bus.trig_in);
      if (accept) mode_lat <= (bus.mode == 2'd3) ? 2'd0 : bus.mode;

      if (next_state == IDLE)
        stop_pending <= 1'b0;
      else if (state != IDLE && bus.stop && mode_lat == 2'd1)
        stop_pending <= 1'b1;

      if (next_state == IDLE) begin
        integ_q  <= 1'b0;
        int_done <= 1'b0;
        tick_cnt <= '0;
        tick_num <= '0;
      end else if (rog_rise) begin
        integ_q  <= 1'b1;
        tick_cnt <= '0;
        tick_num <= '0;
        int_lat  <= (bus.int_time == '0) ? INT_W'(1) : bus.int_time;
      end else if (integ_q) begin
        if (expire) begin
          integ_q  <= 1'b0;
          int_done <= 1'b1;
          tick_cnt <= '0;
          tick_num <= '0;
        end else if (tick_cnt == TK_W'(TICK_DIV - 1)) begin
          tick_cnt <= '0;
          tick_num <= tick_num + INT_W'(1);
        end else begin
          tick_cnt <= tick_cnt + TK_W'(1);
        end
      end
      if (rog_fall) int_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_linear_ccd_timing_gen.sv
// tb/tb_linear_ccd_timing_gen.sv - self-checking bench for linear_ccd_timing_gen
module tb_linear_ccd_timing_gen;
  localparam int CLK_DIV = 4, N_PIX = 8, ROG_SETUP = 3, ROG_LOW = 5, ROG_HOLD = 2;
  localparam int TICK_DIV = 10, ADC_PHASE = 2;
  localparam int RO_LEN = 2 * CLK_DIV * N_PIX;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  linear_ccd_timing_gen_if #(.INT_W(16)) bus ();

  linear_ccd_timing_gen #(
    .CLK_DIV(CLK_DIV), .N_PIX(N_PIX), .ROG_SETUP(ROG_SETUP), .ROG_LOW(ROG_LOW),
    .ROG_HOLD(ROG_HOLD), .TICK_DIV(TICK_DIV), .ADC_PHASE(ADC_PHASE), .INT_W(16)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int rog_fall_q[$], rog_rise_q[$], clk_fall_q[$], strobe_q[$], spix_q[$];
  int fdone_q[$], fstart_q[$], miss_q[$], bfall_q[$];
  logic prev_rog = 1'b1, prev_clk = 1'b1, prev_busy = 1'b0;

  always @(negedge sys_clk) begin
    if (prev_rog && !bus.ccd_rog) rog_fall_q.push_back(cyc);
    if (!prev_rog && bus.ccd_rog) rog_rise_q.push_back(cyc);
    if (prev_clk && !bus.ccd_clk) clk_fall_q.push_back(cyc);
    if (bus.adc_strobe) begin
      strobe_q.push_back(cyc);
      spix_q.push_back(int'(bus.pix_idx));
    end
    if (bus.frame_done)  fdone_q.push_back(cyc);
    if (bus.frame_start) fstart_q.push_back(cyc);
    if (bus.trig_miss)   miss_q.push_back(cyc);
    if (prev_busy && !bus.busy) bfall_q.push_back(cyc);
    prev_rog  <= bus.ccd_rog;
    prev_clk  <= bus.ccd_clk;
    prev_busy <= bus.busy;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    @(posedge sys_clk);
    rog_fall_q.delete(); rog_rise_q.delete(); clk_fall_q.delete(); strobe_q.delete();
    spix_q.delete(); fdone_q.delete(); fstart_q.delete(); miss_q.delete(); bfall_q.delete();
  endtask

  // pulses start (or trig_in in mode 2) during one cycle; returns that cycle number
  task automatic launch(input int mode, input int it, output int s);
    @(negedge sys_clk);
    bus.mode = 2'(mode);
    bus.int_time = 16'(it);
    if (mode == 2) bus.trig_in = 1'b1; else bus.start = 1'b1;
    s = cyc;
    @(negedge sys_clk);
    bus.start = 1'b0;
    bus.trig_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= budget) check({tag, "_timeout"}, 0, 1);
    repeat (2) @(negedge sys_clk);
  endtask

  function automatic int ticks(input int it);
    return ((it == 0) ? 1 : it) * TICK_DIV;
  endfunction

  // one frame from a start/trigger in cycle s: flush, integrate, transfer, read out
  task automatic check_single(input string tag, input int s, input int it);
    int r1, f2, r2, rs;
    int sb = 0, pb = 0;
    r1 = s + 1 + ROG_SETUP + ROG_LOW;
    f2 = r1 + ticks(it) + ROG_SETUP;
    r2 = f2 + ROG_LOW;
    rs = r2 + ROG_HOLD;
    check({tag, "_rogfalls"}, rog_fall_q.size(), 2);
    check({tag, "_rogrises"}, rog_rise_q.size(), 2);
    if (rog_fall_q.size() == 2 && rog_rise_q.size() == 2) begin
      check({tag, "_fall1"}, rog_fall_q[0], s + 1 + ROG_SETUP);
      check({tag, "_rise1"}, rog_rise_q[0], r1);
      check({tag, "_fall2"}, rog_fall_q[1], f2);
      check({tag, "_rise2"}, rog_rise_q[1], r2);
    end
    check({tag, "_strobes"}, strobe_q.size(), N_PIX);
    if (strobe_q.size() == N_PIX) begin
      for (int p = 0; p < N_PIX; p++) begin
        if (strobe_q[p] != rs + 2 * CLK_DIV * p + ADC_PHASE) sb++;
        if (spix_q[p] != p) pb++;
      end
      check({tag, "_strobe_time_errs"}, sb, 0);
      check({tag, "_strobe_pix_errs"}, pb, 0);
    end
    check({tag, "_clkfalls"}, clk_fall_q.size(), N_PIX);
    if (clk_fall_q.size() > 0) check({tag, "_clkfall0"}, clk_fall_q[0], rs);
    check({tag, "_fstart_n"}, fstart_q.size(), 1);
    if (fstart_q.size() == 1) check({tag, "_fstart"}, fstart_q[0], rs);
    check({tag, "_fdone_n"}, fdone_q.size(), 1);
    if (fdone_q.size() == 1) check({tag, "_fdone"}, fdone_q[0], rs + RO_LEN - 1);
    check({tag, "_busyfall_n"}, bfall_q.size(), 1);
    if (bfall_q.size() == 1) check({tag, "_busyfall"}, bfall_q[0], rs + RO_LEN);
  endtask

  // continuous run of 3 frames, stop issued on the third frame_start
  task automatic run_cont(input string tag, input int it);
    int s, n, nf;
    int rexp[4];
    int t;
    clear_log();
    launch(1, it, s);
    nf = 0;
    n = 0;
    while (nf < 3 && n < 3000) begin
      @(negedge sys_clk);
      if (bus.frame_start) nf++;
      n++;
    end
    if (nf < 3) check({tag, "_fstart_timeout"}, nf, 3);
    bus.stop = 1'b1;
    @(negedge sys_clk);
    bus.stop = 1'b0;
    wait_idle(tag, 3000);
    t = ticks(it);
    rexp[0] = s + 1 + ROG_SETUP + ROG_LOW;
    rexp[1] = rexp[0] + t + ROG_SETUP + ROG_LOW;
    for (int k = 2; k < 4; k++)
      rexp[k] = rexp[k-1] + ((t > ROG_HOLD + RO_LEN) ? t : ROG_HOLD + RO_LEN) + ROG_SETUP + ROG_LOW;
    check({tag, "_rises"}, rog_rise_q.size(), 4);
    if (rog_rise_q.size() == 4)
      for (int k = 1; k < 4; k++) check({tag, "_rise"}, rog_rise_q[k], rexp[k]);
    check({tag, "_strobes"}, strobe_q.size(), 3 * N_PIX);
    check({tag, "_fdone_n"}, fdone_q.size(), 3);
    if (fdone_q.size() == 3) begin
      check({tag, "_fdone_last"}, fdone_q[2], rexp[3] + ROG_HOLD + RO_LEN - 1);
      if (bfall_q.size() == 1) check({tag, "_busyfall"}, bfall_q[0], fdone_q[2] + 1);
      else check({tag, "_busyfall_n"}, bfall_q.size(), 1);
    end
  endtask

  initial begin
    int s, it, off, n;
    bus.mode = 2'd0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.trig_in = 1'b0;
    bus.int_time = 16'd3;
    repeat (3) @(negedge sys_clk);
    check("rst_clk", int'(bus.ccd_clk), 1);
    check("rst_rog", int'(bus.ccd_rog), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_pix", int'(bus.pix_idx), 0);
    check("rst_integ", int'(bus.integ_active), 0);
    sys_rst = 1'b0;

    // single shot, int_time=3
    clear_log();
    launch(0, 3, s);
    wait_idle("single", 2000);
    check_single("single", s, 3);

    // continuous: integration-limited, readout-limited, random
    run_cont("cont20", 20);
    run_cont("cont1", 1);
    it = $urandom_range(1, 25);
    run_cont("contrnd", it);

    // external trigger with a second trigger while busy
    clear_log();
    it = $urandom_range(2, 8);
    off = $urandom_range(10, 40);
    launch(2, it, s);
    n = 0;
    while (cyc != s + off && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    bus.trig_in = 1'b1;
    @(negedge sys_clk);
    bus.trig_in = 1'b0;
    wait_idle("trig", 2000);
    check_single("trig", s, it);
    check("trig_miss_n", miss_q.size(), 1);
    if (miss_q.size() == 1) check("trig_miss_at", miss_q[0], s + off + 1);
    clear_log();
    launch(2, it, s);
    wait_idle("trig2", 2000);
    check_single("trig2", s, it);

    // reset in the middle of a readout at pixel 3
    clear_log();
    launch(0, 1, s);
    n = 0;
    while (!(bus.pix_idx == 16'd3 && !bus.ccd_clk) && n < 500) begin
      @(negedge sys_clk);
      n++;
    end
    check("mid_reached_pix3", int'(bus.pix_idx), 3);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("mid_rst_clk", int'(bus.ccd_clk), 1);
    check("mid_rst_rog", int'(bus.ccd_rog), 1);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_pix", int'(bus.pix_idx), 0);
    check("mid_rst_strobe", int'(bus.adc_strobe), 0);
    check("mid_rst_integ", int'(bus.integ_active), 0);
    clear_log();
    launch(0, 1, s);
    wait_idle("after_rst", 2000);
    check_single("after_rst", s, 1);

    // int_time=0 behaves as 1, mode 3 as single shot
    clear_log();
    launch(3, 0, s);
    wait_idle("int0", 2000);
    check_single("int0", s, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/linear_ccd_timing_gen.md
Name: linear_ccd_timing_gen

Overview:
Parametrised timing generator for linear CCD sensors of the ILX511B class. It produces the shift-gate (ROG) and pixel clock (CLK) waveforms, a per-pixel ADC sample strobe and frame handshakes. It supports single-shot, continuous (integration overlapped with readout) and external-trigger modes. It sits between the acquisition control logic and the ADC capture/FIFO path, and replaces fixed-constant timing with parameters.

Parameters:
CLK_DIV, 4, sys_clk cycles per half-period of ccd_clk (>=2)
N_PIX, 2087, ccd_clk periods per readout (>=1)
ROG_SETUP, 3, cycles with ccd_clk high and ROG high before ROG falls
ROG_LOW, 149, cycles ROG is held low
ROG_HOLD, 2, cycles from ROG rise to first ccd_clk fall
TICK_DIV, 100000, sys_clk cycles per integration-time tick
ADC_PHASE, 2, cycle index (0-based) within ccd_clk low phase where adc_strobe fires; must be < CLK_DIV
INT_W, 16, width of int_time

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst  in  1  synchronous, active-high reset
mode  in  2  0 single-shot, 1 continuous, 2 external trigger, 3 treated as 0; latched on accepted start
start  in  1  one-cycle start request (modes 0/1)
stop  in  1  one-cycle stop request (mode 1)
trig_in  in  1  synchronous trigger pulse (mode 2)
int_time  in  INT_W  integration time in ticks; 0 treated as 1
ccd_clk  out  1  sensor CLK
ccd_rog  out  1  sensor ROG, active low
adc_strobe  out  1  one-cycle ADC conversion start per pixel
pix_idx  out  16  index of current pixel, 0..N_PIX-1
frame_start  out  1  one-cycle pulse on first ccd_clk fall of a readout
frame_done  out  1  one-cycle pulse after last pixel's rising edge
busy  out  1  high whenever state != IDLE
integ_active  out  1  high while integration timer runs
trig_miss  out  1  one-cycle pulse when start/trig_in arrives while busy

Behaviour:
- Reset (sys_rst=1 at any time, including mid-frame): next cycle state=IDLE; ccd_clk=1, ccd_rog=1, adc_strobe=0, pix_idx=0, frame_start=0, frame_done=0, busy=0, integ_active=0, trig_miss=0; all counters 0; stop_pending cleared.
- States: IDLE, FLUSH_SETUP, FLUSH_ROG, INTEG, XFER_SETUP, XFER_ROG, HOLD, READOUT, WAIT_INT. Each timed state lasts exactly its parameter count of cycles.
- IDLE: accept start (mode 0/1) or trig_in (mode 2) -> FLUSH_SETUP next cycle. Latch mode.
- FLUSH_SETUP(ROG_SETUP) -> FLUSH_ROG(ROG_LOW, ccd_rog=0) -> INTEG. ccd_rog is registered and is low exactly during *_ROG states.
- Integration timer: (re)starts on the cycle ccd_rog returns high. int_time is latched on that cycle. Expires after max(int_time,1)*TICK_DIV cycles. integ_active is high for that interval; a sticky int_done flag is set at expiry and cleared at the next ROG fall.
- INTEG -> XFER_SETUP on int_done. XFER_SETUP(ROG_SETUP) -> XFER_ROG(ROG_LOW) -> HOLD(ROG_HOLD) -> READOUT.
- READOUT: ccd_clk falls on entry. Each pixel is CLK_DIV cycles low then CLK_DIV cycles high. adc_strobe fires on low-phase cycle ADC_PHASE. pix_idx increments on each rising edge except the last. frame_start fires on the first fall. After the N_PIX-th rise, frame_done fires and pix_idx returns to 0. Readout lasts 2*CLK_DIV*N_PIX cycles.
- End of readout:
  - mode 0/2: -> IDLE.
  - mode 1: if stop_pending -> IDLE; else if int_done -> XFER_SETUP; else -> WAIT_INT, which goes to XFER_SETUP on int_done.
  - Effective continuous integration period = max(int_time*TICK_DIV, readout+ROG_HOLD).
- stop: sets stop_pending only in mode 1 while busy; ignored otherwise. The current readout always completes.
- start/trig_in while busy: ignored; trig_miss pulses. Simultaneous start and stop in IDLE: start wins and stop is ignored.
- ccd_clk stays high in all states except READOUT.

Test Plan:
(Parameters CLK_DIV=4, N_PIX=8, ROG_SETUP=3, ROG_LOW=5, ROG_HOLD=2, TICK_DIV=10, ADC_PHASE=2 unless stated.)
1. Single-shot, mode=0, int_time=3, start at cycle 0 -> first ROG low cycles 4-8; second ROG fall 33 cycles after first rise; ccd_clk low 2 cycles after second rise; exactly 8 adc_strobe pulses, 8 cycles apart, each 2 cycles after a clk fall; frame_done once; busy low after.
2. Continuous, int_time=20 (200 cycles) -> ROG-rise-to-ROG-rise spacing 208 cycles. With int_time=1 -> spacing 74 cycles (readout-limited; state goes straight to XFER_SETUP since the timer has already expired).
3. Continuous, stop asserted mid-readout -> that readout completes with 8 strobes, no further ROG pulse, busy falls the cycle after frame_done.
4. Mode 2, trig_in pulses at cycles 0 and 20 -> one frame; trig_miss pulse at cycle 21; second trig after busy falls starts a new frame.
5. sys_rst asserted during READOUT at pixel 3 -> next cycle all outputs at reset values; a new start produces a full frame from pix_idx 0.
6. int_time=0 -> behaves identically to int_time=1 (10-cycle integration).
